btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Conditions one raw push-button (start or pause) before the stopwatch FSM; the top level instantiates one per button.
- Stages: 2-flop synchroniser, then a debounce state machine with a hold counter.
- Emits a clean level plus single-cycle press/release pulses; the FSM consumes btn_press as its start/pause strobe.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a transition (>=1).
- ACTIVE_HIGH, 1, 1: button reads 1 when pressed; 0: raw input inverted at the synchroniser input.
- LONG_CYCLES, 200000000, hold time in cycles for a long-press pulse (used only with LONG_PRESS_EN).
- CNT_W, 28, counter width; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_raw  in  1  unsynchronised button pin.
- btn_level  out  1  debounced level, 1 = pressed.
- btn_press  out  1  one-cycle pulse on accepted press.
- btn_release  out  1  one-cycle pulse on accepted release.
- btn_long  out  1  one-cycle long-press pulse; tied 0 without LONG_PRESS_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - synchroniser flops, state, counters and all outputs go to 0 / IDLE.
  - Synchroniser reset value is the "not pressed" level.
- Synchroniser: two flops; sync_q = normalised btn_raw delayed 2 edges.
- State IDLE (level=0):
  - sync_q=1 -> PRESS_WAIT, cnt=0.
- PRESS_WAIT:
  - sync_q=1 and cnt<DEBOUNCE_CYCLES-1: cnt++.
  - sync_q=1 and cnt==DEBOUNCE_CYCLES-1: -> PRESSED; btn_press=1 for that one cycle; btn_level=1.
  - sync_q=0: -> IDLE, cnt=0, no pulse (glitch rejected).
- PRESSED (level=1):
  - sync_q=0 -> RELEASE_WAIT, cnt=0.
- RELEASE_WAIT (level stays 1):
  - Mirror of PRESS_WAIT.
  - Stable 0 for DEBOUNCE_CYCLES -> IDLE; btn_release=1 for one cycle; level=0.
  - sync_q=1 -> PRESSED, no pulse.
- Latency: clean raw edge sampled at edge k -> output change/pulse registered at edge k+1+DEBOUNCE_CYCLES+1 (2 sync + DEBOUNCE_CYCLES).
- All outputs are registered; btn_press and btn_release are never high in the same cycle.
- Bounce shorter than DEBOUNCE_CYCLES never produces a pulse; each accepted press gives exactly one btn_press.
- Reset release with button held: starts in IDLE and requires a full debounce, then one btn_press.
- Reset mid-debounce: counter discarded, no pulse emitted.
- Counter never wraps; it is bounded by the compare.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Second counter hcnt clears on entry to PRESSED from PRESS_WAIT.
  - hcnt increments each cycle in PRESSED and RELEASE_WAIT, saturating at LONG_CYCLES.
  - btn_long=1 for one cycle when hcnt reaches LONG_CYCLES-1 (at most once per press).
  - hcnt cleared on entering IDLE.
- Undefined: hcnt logic absent; btn_long constant 0; all other behaviour identical.

Decomposition:
- Shared package watch_pkg:
  - enum btn_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}, 2-bit encoding.
  - Default debounce/long-press cycle constants for the board clock.
- One sub-module sync_2ff: 2-flop synchroniser with parameterised reset value, async active-low rst.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10):
- Clean press: raw 0->1 held 20 cycles -> btn_press high exactly one cycle, 6 edges after first sampling edge; btn_level=1 from same edge; no btn_release.
- Bounce: raw toggles 1,0,1,1,0 then stable 1 -> no pulse until 4 stable synchronised cycles; then exactly one btn_press.
- Release: from PRESSED, raw->0 for 3 cycles then 1 -> returns to PRESSED, no pulses; later raw 0 held 10 cycles -> one btn_release, btn_level=0.
- Reset mid-operation: rst=0 during PRESS_WAIT with cnt=2 -> all outputs 0 immediately (async); release rst with raw=1 -> btn_press 6 edges after release.
- ACTIVE_HIGH=0: raw 1->0 -> behaves as press (btn_press, btn_level=1).
- LONG_PRESS_EN: hold pressed 30 cycles -> one btn_long 10 cycles after btn_press; without macro -> btn_long stays 0.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared stopwatch definitions: button-conditioning state encoding and
// default cycle constants for the board clock.
package watch_pkg;

  // Debounce FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Defaults for the board clock.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd1000000;
  localparam int unsigned LONG_CYCLES_DEF     = 32'd200000000;
  localparam int unsigned CNT_W_DEF           = 32'd28;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk - sampling clock
//   rst - asynchronous active-low reset (flops load RST_VAL)
//   d   - asynchronous input
//   q   - synchronised output, d delayed two clock edges
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a debounce FSM.
// Produces a clean level plus single-cycle press/release pulses.
// Optional long-press pulse enabled by defining the macro LONG_PRESS_EN.
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-low reset
//   btn_raw     - unsynchronised button pin
//   btn_level   - debounced level, 1 = pressed
//   btn_press   - one-cycle pulse on accepted press
//   btn_release - one-cycle pulse on accepted release
//   btn_long    - one-cycle pulse after LONG_CYCLES of hold (0 without LONG_PRESS_EN)
module btn_debounce
  import watch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit          ACTIVE_HIGH     = 1'b1,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  // Reject configurations whose counts cannot be held by the counters.
  if (DEBOUNCE_CYCLES == 0 || LONG_CYCLES == 0 || CNT_W == 0 || CNT_W > 32 ||
      (CNT_W < 32 && (64'(DEBOUNCE_CYCLES) > (64'(1) << CNT_W) ||
                      64'(LONG_CYCLES) >= (64'(1) << CNT_W)))) begin : g_bad_cfg
    $error("btn_debounce: invalid DEBOUNCE_CYCLES/LONG_CYCLES/CNT_W combination");
  end

  // Normalise polarity so everything downstream sees 1 = pressed.
  logic btn_norm;
  logic sync_q;

  assign btn_norm = ACTIVE_HIGH ? btn_raw : ~btn_raw;

  sync_2ff #(
    .RST_VAL(1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_norm),
    .q   (sync_q)
  );

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, press_d, release_d;

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = btn_level;
    press_d   = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (sync_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        level_d = 1'b1;
        if (!sync_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end

      RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LIM  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 32'd1);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             long_d;

  // Hold counter runs while the debounced level is high; saturation at
  // LONG_LIM guarantees a single pulse per press.
  always_comb begin
    hcnt_d = '0;
    long_d = 1'b0;
    if ((state_q == PRESSED || state_q == RELEASE_WAIT) && state_d != IDLE) begin
      hcnt_d = hcnt_q;
      if (hcnt_q != LONG_LIM) begin
        hcnt_d = hcnt_q + CNT_W'(1);
        long_d = (hcnt_q == LONG_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q   <= '0;
      btn_long <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      btn_long <= long_d;
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=10).
// Two instances run in lockstep: active-high on raw, active-low on raw_n.
module tb_btn_debounce;

  localparam int unsigned DB = 4;
  localparam int unsigned LC = 10;
  localparam int unsigned CW = 8;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic raw   = 1'b0;
  logic raw_n = 1'b1;

  logic lvl_a, prs_a, rel_a, lng_a;
  logic lvl_b, prs_b, rel_b, lng_b;

  int checks = 0;
  int errors = 0;
  bit long_en;

  always #5 clk = ~clk;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DB), .ACTIVE_HIGH(1'b1), .LONG_CYCLES(LC), .CNT_W(CW)
  ) u_dut_hi (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_long(lng_a)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DB), .ACTIVE_HIGH(1'b0), .LONG_CYCLES(LC), .CNT_W(CW)
  ) u_dut_lo (
    .clk(clk), .rst(rst), .btn_raw(raw_n),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_long(lng_b)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic lvl, input logic prs, input logic rel);
    chk({tag, "/hi_level"},   lvl_a, lvl);
    chk({tag, "/hi_press"},   prs_a, prs);
    chk({tag, "/hi_release"}, rel_a, rel);
    chk({tag, "/lo_level"},   lvl_b, lvl);
    chk({tag, "/lo_press"},   prs_b, prs);
    chk({tag, "/lo_release"}, rel_b, rel);
  endtask

  task automatic set_raw(input logic v);
    raw   = v;
    raw_n = ~v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] bpat;
    bpat = 5'b01101;  // per-cycle bounce values 1,0,1,1,0 (bit 0 first)
`ifdef LONG_PRESS_EN
    long_en = 1'b1;
`else
    long_en = 1'b0;
`endif

    // Reset state.
    set_raw(1'b0);
    #12;
    chk_all("reset", 1'b0, 1'b0, 1'b0);
    chk("reset/hi_long", lng_a, 1'b0);
    chk("reset/lo_long", lng_b, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("idle[%0d]", i), 1'b0, 1'b0, 1'b0);
    end

    // Clean press held 30 cycles; press on edge 6, long pulse 10 later.
    set_raw(1'b1);
    for (int i = 0; i < 30; i++) begin
      tick();
      chk_all($sformatf("clean[%0d]", i), i >= 6, i == 6, 1'b0);
      chk($sformatf("clean[%0d]/hi_long", i), lng_a, long_en && (i == 16));
      chk($sformatf("clean[%0d]/lo_long", i), lng_b, long_en && (i == 16));
    end

    // Short release glitch: 3 cycles low, then high again.
    set_raw(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("glitch_lo[%0d]", i), 1'b1, 1'b0, 1'b0);
    end
    set_raw(1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("glitch_hi[%0d]", i), 1'b1, 1'b0, 1'b0);
    end

    // Real release.
    set_raw(1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all($sformatf("release[%0d]", i), i < 6, 1'b0, i == 6);
    end

    // Bounce 1,0,1,1,0 then stable 1: last change sampled at edge 5.
    for (int i = 0; i < 20; i++) begin
      set_raw((i < 5) ? bpat[i] : 1'b1);
      tick();
      chk_all($sformatf("bounce[%0d]", i), i >= 11, i == 11, 1'b0);
    end

    // Asynchronous reset while pressed clears outputs without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all($sformatf("in_rst[%0d]", i), 1'b0, 1'b0, 1'b0);
    end

    // Reset release with button held needs a full debounce.
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_all($sformatf("held_rst[%0d]", i), i >= 6, i == 6, 1'b0);
    end

    set_raw(1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all($sformatf("release2[%0d]", i), i < 6, 1'b0, i == 6);
    end

    // Reset in PRESS_WAIT with cnt=2 discards the count.
    set_raw(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("pw[%0d]", i), 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    #1;
    chk_all("pw_rst", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_all($sformatf("pw_in_rst[%0d]", i), 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_all($sformatf("pw_after[%0d]", i), i >= 6, i == 6, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
